// File: rtl/float_pack_pkg.sv
// float_type: shared float classes, FSM states and IEEE-754 single constants
package float_type;
    typedef enum logic [2:0] {
        VALID,
        OVERFLOW,
        UNDERFLOW,
        NaN,
        positive_infinity,
        negative_infinity
    } type_of_float;
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
    localparam int BIAS = 127;
    localparam int EXP_MAX = 255;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] PINF = 32'h7F800000;
    localparam logic [31:0] NINF = 32'hFF800000;
endpackage

// File: rtl/float_pack_if.sv
// float_pack_if: upstream product handshake and downstream packed-result handshake
interface float_pack_if;
    import float_type::*;
    logic         in_valid;
    logic         in_ready;
    logic         in_sign;
    logic [9:0]   in_exp;
    logic [47:0]  in_mant;
    type_of_float in_class;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_float;
    type_of_float out_class;
    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_class, out_ready,
        input  in_ready, out_valid, out_float, out_class
    );
    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_class, out_ready,
        output in_ready, out_valid, out_float, out_class
    );
endinterface

// File: rtl/float_pack_round.sv
// float_round: round-to-nearest-even of a 23-bit fraction using guard and sticky
module float_round (
    input  logic [22:0] frac_i,
    input  logic        guard_i,
    input  logic        sticky_i,
    output logic [22:0] frac_o,
    output logic        carry_o
);
    logic        inc;
    logic [23:0] sum;
    assign inc = guard_i & (sticky_i | frac_i[0]);
    assign sum = {1'b0, frac_i} + {23'd0, inc};
    assign frac_o = sum[22:0];
    assign carry_o = sum[23];
endmodule

// File: rtl/float_pack.sv
// float_pack: normalises, rounds and packs a raw significand product into IEEE-754 single
module float_pack
    import float_type::*;
(
    input  logic        clk,
    input  logic        rst_n,
    float_pack_if.slave bus
);
    state_t              state_q, state_d;
    logic                sign_q, sign_d;
    logic signed [10:0]  exp_q, exp_d;
    logic [47:0]         mant_q, mant_d;
    logic [31:0]         out_float_q, out_float_d;
    type_of_float        out_class_q, out_class_d;
    logic [22:0]         frac;
    logic                carry;
    logic signed [11:0]  res_exp;
    logic                ovf, unf, special, zero;

    float_round u_round (
        .frac_i   (mant_q[46:24]),
        .guard_i  (mant_q[23]),
        .sticky_i (|mant_q[22:0]),
        .frac_o   (frac),
        .carry_o  (carry)
    );

    // exponent of the packed result: mant[47] weighs 2^1, plus any rounding carry
    assign res_exp = {exp_q[10], exp_q} + 12'sd1 + {11'd0, carry};
    assign ovf = res_exp >= 12'(EXP_MAX);
    assign unf = res_exp <= 12'sd0;
    assign special = bus.in_class != VALID;
    assign zero = bus.in_mant == 48'd0;
    assign bus.in_ready = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.out_float = out_float_q;
    assign bus.out_class = out_class_q;

    // state and working registers, cleared by synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            out_float_q <= '0;
            out_class_q <= VALID;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            out_float_q <= out_float_d;
            out_class_q <= out_class_d;
        end
    end

    // capture, one-bit-per-cycle normalisation, rounding/range check, output hold
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        out_float_d = out_float_q;
        out_class_d = out_class_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                sign_d = bus.in_sign;
                exp_d  = {bus.in_exp[9], bus.in_exp};
                mant_d = bus.in_mant;
                state_d = (special || zero) ? DONE : NORM;
                if (special || zero) begin
                    out_float_d = bus.in_class == NaN               ? QNAN :
                                  bus.in_class == positive_infinity ? PINF :
                                  bus.in_class == negative_infinity ? NINF :
                                                                      {bus.in_sign, 31'h0};
                    out_class_d = bus.in_class;
                end
            end
            NORM: begin
                state_d = mant_q[47] ? ROUND : NORM;
                mant_d  = mant_q[47] ? mant_q : mant_q << 1;
                exp_d   = mant_q[47] ? exp_q : exp_q - 11'sd1;
            end
            ROUND: begin
                state_d     = DONE;
                out_float_d = ovf ? {sign_q, 8'hFF, 23'h0} :
                              unf ? {sign_q, 31'h0} :
                                    {sign_q, res_exp[7:0], frac};
                out_class_d = ovf ? OVERFLOW : unf ? UNDERFLOW : VALID;
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
        endcase
    end
endmodule

// File: tb/tb_float_pack.sv
// tb_float_pack: directed vectors with a queue scoreboard and an independent output monitor
module tb_float_pack;
    import float_type::*;

    typedef struct {
        logic [31:0]  f;
        type_of_float c;
        int           lat;
        int           hold;
        int           xfer;
    } exp_t;

    logic clk = 0;
    logic rst_n;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t q[$];

    float_pack_if bus();

    float_pack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic wait_idle;
        int n = 0;
        @(negedge clk);
        while (!(bus.in_ready === 1'b1 && q.size() == 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_total++;
            $display("FAIL idle_timeout: in_ready=%b pending=%0d", bus.in_ready, q.size());
        end
    endtask

    task automatic send(input logic s, input logic [9:0] e, input logic [47:0] m,
                        input type_of_float c, input logic [31:0] f, input type_of_float rc,
                        input int lat, input int hold, input bit junk);
        exp_t x;
        wait_idle();
        bus.in_valid = 1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_mant  = m;
        bus.in_class = c;
        @(posedge clk);
        #1;
        bus.in_valid = 0;
        x.f = f; x.c = rc; x.lat = lat; x.hold = hold; x.xfer = cyc;
        q.push_back(x);
        if (junk) begin
            bus.in_valid = 1;
            bus.in_class = NaN;
            bus.in_mant  = 48'h123456789ABC;
            repeat (10) @(posedge clk);
            #1;
            bus.in_valid = 0;
            bus.in_class = VALID;
        end
    endtask

    // monitor: checks every presented result against the head of the scoreboard
    initial begin
        exp_t e;
        int   held = 0;
        bit   seen = 0;
        bus.out_ready = 1;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_out_valid: out_float=%h with nothing pending", bus.out_float);
                    bus.out_ready = 1;
                end else begin
                    e = q[0];
                    if (!seen) begin
                        chk("latency", 32'(cyc - e.xfer + 1), 32'(e.lat));
                        seen = 1;
                        held = 0;
                    end
                    chk("out_float", bus.out_float, e.f);
                    chk("out_class", 32'(bus.out_class), 32'(e.c));
                    chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
                    if (held >= e.hold) begin
                        bus.out_ready = 1;
                        void'(q.pop_front());
                        seen = 0;
                    end else begin
                        bus.out_ready = 0;
                        held++;
                    end
                end
            end else begin
                bus.out_ready = (q.size() == 0) || (q[0].hold == 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov_seen = 0;
        rst_n = 0;
        bus.in_valid = 0;
        bus.in_sign  = 0;
        bus.in_exp   = '0;
        bus.in_mant  = '0;
        bus.in_class = VALID;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_float", bus.out_float, 32'h0);
        chk("rst_out_class", 32'(bus.out_class), 32'(VALID));
        rst_n = 1;

        send(0, 10'd127, 48'h900000000000, VALID, 32'h40100000, VALID, 3, 0, 0);
        send(0, 10'd127, 48'h400000000000, VALID, 32'h3F800000, VALID, 4, 0, 0);
        send(0, 10'd127, 48'h800000800000, VALID, 32'h40000000, VALID, 3, 0, 0);
        send(0, 10'd127, 48'h800001800000, VALID, 32'h40000002, VALID, 3, 5, 0);
        send(0, 10'd254, 48'h800000000000, VALID, 32'h7F800000, OVERFLOW, 3, 0, 0);
        send(1, 10'h3FB, 48'h800000000000, VALID, 32'h80000000, UNDERFLOW, 3, 0, 0);
        send(1, 10'd127, 48'h800000000000, NaN, 32'h7FC00000, NaN, 1, 0, 0);
        send(1, 10'd127, 48'h800000000000, negative_infinity, 32'hFF800000, negative_infinity, 1, 0, 0);
        send(0, 10'd127, 48'h800000000000, positive_infinity, 32'h7F800000, positive_infinity, 1, 0, 0);
        send(0, 10'd127, 48'hFFFFFF800000, VALID, 32'h40800000, VALID, 3, 0, 0);
        send(0, 10'd253, 48'hFFFFFF800000, VALID, 32'h7F800000, OVERFLOW, 3, 0, 0);
        send(1, 10'h3FF, 48'h800000000000, VALID, 32'h80000000, UNDERFLOW, 3, 0, 0);
        send(0, 10'd0, 48'h800000000000, VALID, 32'h00800000, VALID, 3, 0, 0);
        send(1, 10'd5, 48'h000000000000, VALID, 32'h80000000, VALID, 1, 0, 0);
        send(0, 10'd150, 48'h000001000000, VALID, 32'h40000000, VALID, 26, 0, 1);

        wait_idle();
        bus.in_valid = 1;
        bus.in_sign  = 0;
        bus.in_exp   = 10'd0;
        bus.in_mant  = 48'h1;
        bus.in_class = VALID;
        @(posedge clk);
        #1;
        bus.in_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (60) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) ov_seen++;
        end
        chk("midrst_no_output", 32'(ov_seen), 32'd0);

        send(0, 10'd127, 48'h400000000000, VALID, 32'h3F800000, VALID, 4, 0, 0);
        wait_idle();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/float_pack.md
FLOAT_PACK -- requirements
Module: float_pack

Interface
REQ-001 Parameters: none; all widths fixed by IEEE-754 single precision.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  upstream result available.
REQ-005 in_ready  output  1  block can accept; high only in IDLE.
REQ-006 in_sign  input  1  product sign.
REQ-007 in_exp  input  10  two's-complement biased exponent (ea+eb-127); may be outside 1..254.
REQ-008 in_mant  input  48  raw significand product; value = in_mant/2^46.
REQ-009 in_class  input  type_of_float  operand class from the classifier (VALID, positive_infinity, negative_infinity, NaN).
REQ-010 out_valid  output  1  packed result held stable.
REQ-011 out_ready  input  1  downstream accepts.
REQ-012 out_float  output  32  packed IEEE-754 single.
REQ-013 out_class  output  type_of_float  VALID, OVERFLOW, UNDERFLOW, NaN, positive_infinity, negative_infinity.

Function
REQ-014 FSM states IDLE, NORM, ROUND, DONE; transfer occurs when valid and ready are both high on a rising edge.
REQ-015 IDLE: on input transfer, capture sign/mant/class; sign-extend exp into an 11-bit signed working register; go to NORM, or directly to DONE for special class or in_mant==0.
REQ-016 NORM: if mant[47]==1 go to ROUND; else shift mant left 1, decrement exp, stay; one bit per cycle, max 47 shifts.
REQ-017 ROUND: frac=mant[46:24], guard=mant[23], sticky=OR(mant[22:0]); increment frac when guard AND (sticky OR frac[0]); result exponent = exp+1, plus 1 more if frac increment carries out (frac becomes 0).
REQ-018 Range: result exponent >=255 -> {sign,8'hFF,23'h0}, class OVERFLOW; result exponent <=0 -> {sign,31'h0}, class UNDERFLOW (flush to zero, no subnormals); else VALID.
REQ-019 Specials: NaN -> 32'h7FC00000 class NaN; positive_infinity -> 32'h7F800000; negative_infinity -> 32'hFF800000; in_mant==0 with VALID -> {sign,31'h0} class VALID.
REQ-020 Latency from input transfer (cycle 0): mant[47] set -> out_valid at cycle 3; each leading zero adds one cycle; special/zero -> out_valid at cycle 1.
REQ-021 DONE: out_valid high, out_float/out_class stable until out_ready transfer; then IDLE and in_ready high next cycle.
REQ-022 No new input accepted while busy; in_valid outside IDLE ignored.
REQ-023 Sign bit of every output equals captured sign except NaN (sign 0).

Reset
REQ-024 rst_n low at a clock edge: state IDLE, in_ready 1, out_valid 0, out_float 0, out_class VALID, working registers 0.
REQ-025 Reset mid-operation discards the in-flight result; no out_valid follows.

Structure
REQ-026 type_of_float extended with OVERFLOW/UNDERFLOW, state enum, and constants (bias 127, EXP_MAX 255, QNAN 32'h7FC00000) live in package float_type.
REQ-027 One sub-module natural: float_round (combinational RNE on 24-bit mantissa+guard+sticky returning frac and carry).
REQ-028 Target size 120-400 RTL lines; no multiplier inside.

Verification
REQ-029 mant=48'h900000000000, exp=127, sign 0 (1.5*1.5) -> 32'h40100000 VALID, out_valid cycle 3.
REQ-030 mant=48'h400000000000, exp=127 (1.0*1.0) -> 32'h3F800000 VALID, out_valid cycle 4.
REQ-031 mant=48'h800000800000, exp=127 -> 32'h40000000 (tie, even, down); mant=48'h800001800000 -> 32'h40000002 (tie, up).
REQ-032 mant=48'h800000000000, exp=254, sign 0 -> 32'h7F800000 OVERFLOW; exp=-5, sign 1 -> 32'h80000000 UNDERFLOW.
REQ-033 class NaN -> 32'h7FC00000 at cycle 1; class negative_infinity -> 32'hFF800000.
REQ-034 out_ready held low 5 cycles -> out_float stable, in_ready 0; rst_n low during NORM -> IDLE next cycle, out_valid never asserted.
